cmd_cfg: RTL and testbench

CMD_CFG -- requirements
Module: cmd_cfg

---
 rtl/cmd_cfg.sv | 179 +++++++++++++++++
 tb/tb_cmd_cfg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_cfg.sv
// ============================================================================
// cmd_cfg -- command decoder, setpoint registers and watchdog for the flight core
// Rev 1.0
// ============================================================================
`default_nettype none

module cmd_cfg #(
  parameter int         WD_W = 26,
  parameter logic [7:0] ACK  = 8'hA5,
  parameter logic [7:0] NAK  = 8'hEE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_rdy,
  input  logic [7:0]  cmd,
  input  logic [15:0] data,
  output logic        clr_cmd_rdy,
  output logic [7:0]  resp,
  output logic        send_resp,
  input  logic        resp_sent,
  input  logic [7:0]  batt,
  input  logic        cal_done,
  output logic        strt_cal,
  output logic        inertial_cal,
  output logic [15:0] d_ptch,
  output logic [15:0] d_roll,
  output logic [15:0] d_yaw,
  output logic [8:0]  thrst,
  output logic        mtrs_off
);

  localparam logic [7:0] OP_SET_PTCH  = 8'h01;
  localparam logic [7:0] OP_SET_ROLL  = 8'h02;
  localparam logic [7:0] OP_SET_YAW   = 8'h03;
  localparam logic [7:0] OP_GET_BATT  = 8'h04;
  localparam logic [7:0] OP_SET_THRST = 8'h05;
  localparam logic [7:0] OP_CALIBRATE = 8'h06;
  localparam logic [7:0] OP_EMER_LAND = 8'h07;
  localparam logic [7:0] OP_MTRS_OFF  = 8'h08;

  localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_MAX = {WD_W{1'b1}};
  localparam logic [WD_W-1:0] WD_PRE = WD_MAX - WD_ONE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CAL_WAIT  = 2'd1,
    RESP_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [15:0]       d_ptch_q, d_ptch_d, d_roll_q, d_roll_d, d_yaw_q, d_yaw_d;
  logic [8:0]        thrst_q, thrst_d;
  logic [7:0]        resp_q, resp_d;
  logic              clr_q, clr_d, send_q, send_d, strt_q, strt_d;
  logic              ical_q, ical_d, mtrs_off_q, mtrs_off_d;
  logic              accept;

  always_comb begin
    state_d    = state_q;
    wd_cnt_d   = wd_cnt_q;
    d_ptch_d   = d_ptch_q;
    d_roll_d   = d_roll_q;
    d_yaw_d    = d_yaw_q;
    thrst_d    = thrst_q;
    resp_d     = resp_q;
    ical_d     = ical_q;
    mtrs_off_d = mtrs_off_q;
    clr_d      = 1'b0;
    send_d     = 1'b0;
    strt_d     = 1'b0;
    accept     = (state_q == IDLE) && cmd_rdy;

    // Expiry fires once, on the edge the counter lands on all-ones; acceptance pre-empts it.
    if (accept) begin
      wd_cnt_d = '0;
    end else begin
      if (wd_cnt_q != WD_MAX) wd_cnt_d = wd_cnt_q + WD_ONE;
      if (wd_cnt_q == WD_PRE) begin
        mtrs_off_d = 1'b1;
        thrst_d    = '0;
      end
    end

    case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_d   = 1'b1;
          send_d  = 1'b1;
          resp_d  = ACK;
          state_d = RESP_WAIT;
          case (cmd)
            OP_SET_PTCH:  d_ptch_d = data;
            OP_SET_ROLL:  d_roll_d = data;
            OP_SET_YAW:   d_yaw_d  = data;
            OP_GET_BATT:  resp_d   = batt;
            OP_SET_THRST: thrst_d  = data[8:0];
            OP_CALIBRATE: begin
              send_d     = 1'b0;
              resp_d     = resp_q;
              strt_d     = 1'b1;
              ical_d     = 1'b1;
              mtrs_off_d = 1'b0;
              state_d    = CAL_WAIT;
            end
            OP_EMER_LAND: begin
              d_ptch_d = '0;
              d_roll_d = '0;
              d_yaw_d  = '0;
              thrst_d  = '0;
            end
            OP_MTRS_OFF: begin
              mtrs_off_d = 1'b1;
              thrst_d    = '0;
            end
            default:      resp_d = NAK;
          endcase
        end
      end
      CAL_WAIT: begin
        if (cal_done) begin
          ical_d  = 1'b0;
          resp_d  = ACK;
          send_d  = 1'b1;
          state_d = RESP_WAIT;
        end
      end
      RESP_WAIT: begin
        if (resp_sent) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wd_cnt_q   <= '0;
      d_ptch_q   <= '0;
      d_roll_q   <= '0;
      d_yaw_q    <= '0;
      thrst_q    <= '0;
      resp_q     <= 8'h00;
      clr_q      <= 1'b0;
      send_q     <= 1'b0;
      strt_q     <= 1'b0;
      ical_q     <= 1'b0;
      mtrs_off_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      wd_cnt_q   <= wd_cnt_d;
      d_ptch_q   <= d_ptch_d;
      d_roll_q   <= d_roll_d;
      d_yaw_q    <= d_yaw_d;
      thrst_q    <= thrst_d;
      resp_q     <= resp_d;
      clr_q      <= clr_d;
      send_q     <= send_d;
      strt_q     <= strt_d;
      ical_q     <= ical_d;
      mtrs_off_q <= mtrs_off_d;
    end
  end

  assign clr_cmd_rdy  = clr_q;
  assign resp         = resp_q;
  assign send_resp    = send_q;
  assign strt_cal     = strt_q;
  assign inertial_cal = ical_q;
  assign d_ptch       = d_ptch_q;
  assign d_roll       = d_roll_q;
  assign d_yaw        = d_yaw_q;
  assign thrst        = thrst_q;
  assign mtrs_off     = mtrs_off_q;

endmodule

`default_nettype wire

// File: tb/tb_cmd_cfg.sv
// ============================================================================
// tb_cmd_cfg -- randomized self-checking bench for cmd_cfg against a transaction model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_cmd_cfg;

  localparam int         WD_W   = 4;
  localparam int         WD_EXP = (1 << WD_W) - 1;
  localparam logic [7:0] ACK    = 8'hA5;
  localparam logic [7:0] NAK    = 8'hEE;

  logic        clk = 1'b0;
  logic        rst, cmd_rdy, resp_sent, cal_done;
  logic [7:0]  cmd, batt;
  logic [15:0] data;
  logic        clr_cmd_rdy, send_resp, strt_cal, inertial_cal, mtrs_off;
  logic [7:0]  resp;
  logic [15:0] d_ptch, d_roll, d_yaw;
  logic [8:0]  thrst;

  int n_total = 0;
  int n_bad   = 0;

  // reference model state
  logic [15:0] m_ptch, m_roll, m_yaw;
  logic [8:0]  m_thrst;
  logic [7:0]  m_resp;
  logic        m_mtrs, m_ical, m_clr, m_send, m_strt;
  int          m_since;

  cmd_cfg #(.WD_W(WD_W), .ACK(ACK), .NAK(NAK)) dut (
    .clk(clk), .rst(rst), .cmd_rdy(cmd_rdy), .cmd(cmd), .data(data),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .send_resp(send_resp),
    .resp_sent(resp_sent), .batt(batt), .cal_done(cal_done),
    .strt_cal(strt_cal), .inertial_cal(inertial_cal),
    .d_ptch(d_ptch), .d_roll(d_roll), .d_yaw(d_yaw),
    .thrst(thrst), .mtrs_off(mtrs_off)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check_val("clr_cmd_rdy",  32'(clr_cmd_rdy),  32'(m_clr));
    check_val("send_resp",    32'(send_resp),    32'(m_send));
    check_val("strt_cal",     32'(strt_cal),     32'(m_strt));
    check_val("inertial_cal", 32'(inertial_cal), 32'(m_ical));
    check_val("mtrs_off",     32'(mtrs_off),     32'(m_mtrs));
    check_val("resp",         32'(resp),         32'(m_resp));
    check_val("d_ptch",       32'(d_ptch),       32'(m_ptch));
    check_val("d_roll",       32'(d_roll),       32'(m_roll));
    check_val("d_yaw",        32'(d_yaw),        32'(m_yaw));
    check_val("thrst",        32'(thrst),        32'(m_thrst));
  endtask

  // One clock edge: the caller says whether a command is accepted or calibration completes.
  task automatic tick(input bit acc, input logic [7:0] op, input logic [15:0] dat, input bit cal_ev);
    logic [7:0] b;
    b = batt;
    @(posedge clk);
    m_clr  = 1'b0;
    m_send = 1'b0;
    m_strt = 1'b0;
    if (acc) begin
      m_since = 0;
      m_clr   = 1'b1;
      if (op == 8'h06) begin
        m_strt = 1'b1;
        m_ical = 1'b1;
        m_mtrs = 1'b0;
      end else begin
        m_send = 1'b1;
        m_resp = ACK;
        case (op)
          8'h01: m_ptch = dat;
          8'h02: m_roll = dat;
          8'h03: m_yaw = dat;
          8'h04: m_resp = b;
          8'h05: m_thrst = dat[8:0];
          8'h07: begin m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; end
          8'h08: begin m_mtrs = 1'b1; m_thrst = 0; end
          default: m_resp = NAK;
        endcase
      end
    end else begin
      if (m_since < 1000) m_since++;
      if (m_since == WD_EXP) begin
        m_mtrs  = 1'b1;
        m_thrst = 0;
      end
    end
    if (cal_ev) begin
      m_ical = 1'b0;
      m_resp = ACK;
      m_send = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    m_ptch = 0; m_roll = 0; m_yaw = 0; m_thrst = 0; m_resp = 8'h00;
    m_clr = 0; m_send = 0; m_strt = 0; m_ical = 0; m_mtrs = 1'b1; m_since = 0;
    #1;
    check_all();
    rst = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    cmd_rdy = 1'b0;
    for (int i = 0; i < n; i++) begin
      cal_done  = 1'($urandom);
      resp_sent = 1'($urandom);
      tick(1'b0, 8'h00, 16'h0, 1'b0);
    end
    cal_done  = 1'b0;
    resp_sent = 1'b0;
  endtask

  // Full transaction from IDLE back to IDLE.
  task automatic run_cmd(input logic [7:0] op, input logic [15:0] dat, input logic [7:0] bv,
                         input int cal_wait, input int resp_wait);
    cmd = op; data = dat; batt = bv;
    cmd_rdy = 1'b1; cal_done = 1'b0; resp_sent = 1'b0;
    tick(1'b1, op, dat, 1'b0);
    cmd_rdy = 1'b0;
    batt = 8'($urandom);
    if (op == 8'h06) begin
      for (int i = 0; i < cal_wait; i++) begin
        resp_sent = 1'($urandom);
        tick(1'b0, 8'h00, 16'h0, 1'b0);
      end
      resp_sent = 1'b0;
      cal_done  = 1'b1;
      tick(1'b0, 8'h00, 16'h0, 1'b1);
      cal_done = 1'b0;
    end
    for (int i = 0; i < resp_wait; i++) begin
      cal_done = 1'($urandom);
      tick(1'b0, 8'h00, 16'h0, 1'b0);
    end
    cal_done  = 1'b0;
    resp_sent = 1'b1;
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    resp_sent = 1'b0;
  endtask

  initial begin
    logic [7:0] op;
    int r;
    rst = 1'b1; cmd_rdy = 1'b0; resp_sent = 1'b0; cal_done = 1'b0;
    cmd = 8'h00; data = 16'h0; batt = 8'h00;
    #2;
    do_reset();

    // directed scenarios
    run_cmd(8'h01, 16'hFF38, 8'h00, 0, 3);
    run_cmd(8'h04, 16'h1234, 8'hC3, 0, 2);
    run_cmd(8'h06, 16'h0000, 8'h00, 20, 1);
    run_cmd(8'h05, 16'hFFFF, 8'h00, 0, 0);
    run_cmd(8'h07, 16'h0000, 8'h00, 0, 0);
    run_cmd(8'h01, 16'h0101, 8'h00, 0, 0);
    run_cmd(8'h3C, 16'hAAAA, 8'h00, 0, 1);

    // watchdog expiry with no commands, then acceptance on the expiry edge
    run_cmd(8'h06, 16'h0, 8'h00, 0, 0);
    run_cmd(8'h05, 16'h0055, 8'h00, 0, 0);
    idle_gap(WD_EXP + 3);
    run_cmd(8'h06, 16'h0, 8'h00, 0, 0);
    run_cmd(8'h05, 16'h0055, 8'h00, 0, 0);
    if (m_since < WD_EXP - 1) idle_gap(WD_EXP - 1 - m_since);
    check_val("wd_pre_expiry", 32'(m_since), 32'(WD_EXP - 1));
    run_cmd(8'h01, 16'h7777, 8'h00, 0, 0);
    check_val("mtrs_off_after_coincide", 32'(mtrs_off), 32'd0);
    idle_gap(WD_EXP + 2);

    // command raised during RESP_WAIT stays pending until IDLE
    cmd = 8'h01; data = 16'h1111; cmd_rdy = 1'b1;
    tick(1'b1, 8'h01, 16'h1111, 1'b0);
    cmd_rdy = 1'b0;
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    cmd = 8'h02; data = 16'h2222; cmd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 16'h0, 1'b0);
    resp_sent = 1'b1;
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    resp_sent = 1'b0;
    tick(1'b1, 8'h02, 16'h2222, 1'b0);
    cmd_rdy = 1'b0;
    resp_sent = 1'b1;
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    resp_sent = 1'b0;

    // reset in the middle of calibration
    cmd = 8'h06; cmd_rdy = 1'b1;
    tick(1'b1, 8'h06, 16'h0, 1'b0);
    cmd_rdy = 1'b0;
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    tick(1'b0, 8'h00, 16'h0, 1'b0);
    do_reset();
    idle_gap(3);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 11));
      op = (r <= 8) ? 8'(r) : 8'($urandom);
      run_cmd(op, 16'($urandom), 8'($urandom),
              int'($urandom_range(0, 20)), int'($urandom_range(0, 4)));
      idle_gap(int'($urandom_range(0, 18)));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
